// File: rtl/fifo_tx_sched_pkg.sv
// rtl/fifo_tx_sched_pkg.sv - state encoding and default timing constants for fifo_tx_sched
package fifo_tx_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  localparam int DEF_BUSY_TIMEOUT = 16;
  localparam int DEF_GAP_CYCLES   = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fifo_tx_sched.sv
// rtl/fifo_tx_sched.sv - pops bytes from a FIFO and hands them one at a time to a serializer
// Optional macro FIFO_TX_SCHED_CNT_EN adds the sent_cnt completed-byte counter.
module fifo_tx_sched
  import fifo_tx_sched_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] R_data,
  output logic                  R_inc,
  input  logic                  tx_busy,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  timeout_err
`ifdef FIFO_TX_SCHED_CNT_EN
  ,
  output logic [15:0]           sent_cnt
`endif
);

  // One down-counter serves both the busy timeout and the inter-byte gap.
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);
  localparam int CNT_W = max_int(max_int(GAP_W, TO_W), 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             pop;
  logic             err_set;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pop     = 1'b0;
    err_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && !empty && !tx_busy) begin
          pop     = 1'b1;
          state_n = ST_SEND;
        end
      end
      ST_SEND: begin
        state_n = ST_WAIT_BUSY;
        cnt_n   = TO_LOAD;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_n = ST_WAIT_DONE;
          cnt_n   = '0;
        end else if (cnt == '0) begin
          // The byte is dropped; it has already left the FIFO.
          err_set = 1'b1;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (GAP_CYCLES > 0) begin
            state_n = ST_GAP;
            cnt_n   = GAP_LOAD;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (cnt == '0) state_n = ST_IDLE;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign R_inc    = pop & ~RST;
  assign tx_valid = (state == ST_SEND);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      tx_data     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (pop)     tx_data     <= R_data;
      if (err_set) timeout_err <= 1'b1;
    end
  end

`ifdef FIFO_TX_SCHED_CNT_EN
  logic done;
  assign done = (state == ST_WAIT_DONE) && !tx_busy;

  always_ff @(posedge CLK) begin
    if (RST)       sent_cnt <= '0;
    else if (done) sent_cnt <= sent_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_tx_sched.sv
// tb/tb_fifo_tx_sched.sv - directed self-checking bench for fifo_tx_sched
// Extra sent_cnt checks are compiled when FIFO_TX_SCHED_CNT_EN is defined.
module tb_fifo_tx_sched;

  localparam int GAP = 2;

  logic       CLK = 1'b0;
  logic       RST;
  logic       enable;
  logic       empty;
  logic [7:0] R_data;
  logic       R_inc;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       timeout_err;
`ifdef FIFO_TX_SCHED_CNT_EN
  logic [15:0] sent_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:15];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int p0;

  assign empty  = (rd_ptr == wr_ptr);
  assign R_data = mem[rd_ptr[3:0]];

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (R_inc) rd_ptr <= rd_ptr + 1;

  fifo_tx_sched dut (
    .CLK         (CLK),
    .RST         (RST),
    .enable      (enable),
    .empty       (empty),
    .R_data      (R_data),
    .R_inc       (R_inc),
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .timeout_err (timeout_err)
`ifdef FIFO_TX_SCHED_CNT_EN
    ,
    .sent_cnt    (sent_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[3:0]] = b;
    wr_ptr++;
  endtask

  // Entered at a negedge+1 where a pop is due; returns at the IDLE negedge+1 after the gap.
  task automatic xfer(input logic [7:0] b, input int busy_len, input bit drop_en);
    check("pop", {31'd0, R_inc}, 32'd1);
    @(negedge CLK); #1;
    check("valid", {31'd0, tx_valid}, 32'd1);
    check("data", {24'd0, tx_data}, {24'd0, b});
    @(negedge CLK); #1;
    check("valid_one_cycle", {31'd0, tx_valid}, 32'd0);
    tx_busy = 1'b1;
    for (int i = 0; i < busy_len; i++) begin
      @(negedge CLK); #1;
      if (drop_en && i == 0) enable = 1'b0;
      check("no_pop_busy", {31'd0, R_inc}, 32'd0);
    end
    tx_busy = 1'b0;
    #1;
    check("no_pop_done", {31'd0, R_inc}, 32'd0);
    for (int i = 0; i < GAP; i++) begin
      @(negedge CLK); #1;
      check("no_pop_gap", {31'd0, R_inc}, 32'd0);
    end
    @(negedge CLK); #1;
  endtask

  initial begin
    RST = 1'b1; enable = 1'b0; tx_busy = 1'b0;
    repeat (2) @(negedge CLK);
    // Data available and enabled while reset is held: no pop.
    push(8'hA5); enable = 1'b1; #1;
    check("rinc_in_reset", {31'd0, R_inc}, 32'd0);
    RST = 1'b0; #1;
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);
    check("rst_err", {31'd0, timeout_err}, 32'd0);
    xfer(8'hA5, 10, 1'b0);
    check("idle_empty", {31'd0, R_inc}, 32'd0);

    // Three queued bytes go out in order.
    p0 = rd_ptr;
    push(8'h11); push(8'h22); push(8'h33); #1;
    xfer(8'h11, 3, 1'b0);
    xfer(8'h22, 3, 1'b0);
    xfer(8'h33, 3, 1'b0);
    check("three_pops", rd_ptr - p0, 32'd3);
    check("fifo_drained", {31'd0, empty}, 32'd1);
    check("no_pop_empty", {31'd0, R_inc}, 32'd0);

    // Serializer never goes busy: timeout after 16 WAIT_BUSY cycles.
    push(8'h44); push(8'h55); #1;
    check("pop_44", {31'd0, R_inc}, 32'd1);
    @(negedge CLK); #1;
    check("valid_44", {31'd0, tx_valid}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK); #1;
      check("err_not_yet", {31'd0, timeout_err}, 32'd0);
      check("no_pop_wait", {31'd0, R_inc}, 32'd0);
    end
    @(negedge CLK); #1;
    check("err_set", {31'd0, timeout_err}, 32'd1);
    xfer(8'h55, 4, 1'b0);
    check("err_sticky", {31'd0, timeout_err}, 32'd1);
`ifdef FIFO_TX_SCHED_CNT_EN
    check("cnt_five_no_timeout", {16'd0, sent_cnt}, 32'd5);
`endif

    // enable drops while the frame is on the wire.
    push(8'h66); push(8'h77); #1;
    xfer(8'h66, 4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("no_pop_disabled", {31'd0, R_inc}, 32'd0);
      check("data_held", {24'd0, tx_data}, 32'h66);
      @(negedge CLK); #1;
    end
    enable = 1'b1; #1;
    xfer(8'h77, 2, 1'b0);

    // Reset during WAIT_BUSY abandons the byte.
    push(8'h88); #1;
    check("pop_88", {31'd0, R_inc}, 32'd1);
    @(negedge CLK); #1;
    check("valid_88", {31'd0, tx_valid}, 32'd1);
    @(negedge CLK); #1;
    RST = 1'b1; #1;
    check("rinc_rst_wait", {31'd0, R_inc}, 32'd0);
    @(negedge CLK); #1;
    check("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
    check("mid_rst_err", {31'd0, timeout_err}, 32'd0);
    check("mid_rst_data", {24'd0, tx_data}, 32'd0);
    push(8'h99); #1;
    check("rinc_rst_idle", {31'd0, R_inc}, 32'd0);
    RST = 1'b0; #1;
    xfer(8'h99, 2, 1'b0);
    check("fifo_drained_end", {31'd0, empty}, 32'd1);

`ifdef FIFO_TX_SCHED_CNT_EN
    check("cnt_after_rst", {16'd0, sent_cnt}, 32'd1);
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4); #1;
    xfer(8'hC1, 1, 1'b0);
    xfer(8'hC2, 1, 1'b0);
    xfer(8'hC3, 1, 1'b0);
    xfer(8'hC4, 1, 1'b0);
    check("cnt_five", {16'd0, sent_cnt}, 32'd5);
    force dut.sent_cnt = 16'hFFFF;
    @(negedge CLK);
    release dut.sent_cnt;
    #1;
    check("cnt_preload", {16'd0, sent_cnt}, 32'hFFFF);
    push(8'hD0); #1;
    xfer(8'hD0, 2, 1'b0);
    check("cnt_wrap", {16'd0, sent_cnt}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_tx_sched.md
FIFO_TX_SCHED -- requirements
Module: fifo_tx_sched

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of the FIFO read data and the transmit data.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 2, giving the idle cycles inserted after each byte (0 = no gap).
REQ-003 The block SHALL have parameter BUSY_TIMEOUT, default 16, giving the maximum cycles to wait for tx_busy to rise after tx_valid.
REQ-004 CLK  input  1  single clock (the FIFO read clock); all logic on its rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  permits new transfers; sampled only in IDLE.
REQ-007 empty  input  1  FIFO empty flag, read side.
REQ-008 R_data  input  DATA_WIDTH  FIFO read data, valid combinationally while empty=0.
REQ-009 R_inc  output  1  FIFO pop strobe, one cycle per byte.
REQ-010 tx_busy  input  1  serializer busy, high for the whole frame.
REQ-011 tx_data  output  DATA_WIDTH  registered byte presented to the serializer.
REQ-012 tx_valid  output  1  one-cycle start strobe to the serializer.
REQ-013 timeout_err  output  1  sticky error: tx_busy did not rise within BUSY_TIMEOUT.
REQ-014 sent_cnt  output  16  completed-byte count; exists only with FIFO_TX_SCHED_CNT_EN.

Function
REQ-015 The FSM SHALL have the states IDLE, SEND, WAIT_BUSY, WAIT_DONE and GAP.
REQ-016 IDLE with enable=1, empty=0 and tx_busy=0: R_inc=1 for that cycle, tx_data<=R_data at the same edge, next state SEND.
REQ-017 R_inc SHALL be combinational from state and inputs, asserted only under REQ-016, and never when empty=1.
REQ-018 SEND: tx_valid=1 for exactly one cycle, next state WAIT_BUSY; latency from pop to tx_valid is 1 cycle.
REQ-019 WAIT_BUSY: on tx_busy=1 go to WAIT_DONE and clear the timeout counter.
REQ-020 WAIT_BUSY: if tx_busy stays 0 for BUSY_TIMEOUT cycles, set timeout_err=1, drop the byte, and go to IDLE.
REQ-021 WAIT_DONE: on tx_busy=0 the byte is complete; go to GAP if GAP_CYCLES>0, else to IDLE.
REQ-022 GAP: count GAP_CYCLES cycles, then go to IDLE; the gap counter width is $clog2(GAP_CYCLES+1).
REQ-023 tx_data SHALL hold its value from the pop until the next pop.
REQ-024 enable falling mid-transfer: the current byte completes; no further pops occur.
REQ-025 empty rising outside IDLE SHALL have no effect.
REQ-026 Back-to-back bytes SHALL be spaced at least 1 (SEND) + frame + GAP_CYCLES + 1 cycles apart.
REQ-027 timeout_err SHALL be cleared only by RST.

Reset
REQ-028 On RST=1 at a clock edge the following SHALL be forced: state=IDLE, tx_valid=0, tx_data=0, timeout_err=0, all counters=0, sent_cnt=0.
REQ-029 R_inc SHALL be 0 during every cycle in which RST=1.
REQ-030 Reset mid-transfer SHALL abandon the byte with no retry.

Configuration
REQ-031 With macro FIFO_TX_SCHED_CNT_EN defined, sent_cnt SHALL exist and increment by 1 on each WAIT_DONE exit, wrapping 16'hFFFF->0.
REQ-032 Timed-out bytes SHALL NOT increment sent_cnt.
REQ-033 Without FIFO_TX_SCHED_CNT_EN, the sent_cnt port and its counter SHALL be absent.

Structure
REQ-034 Package fifo_tx_sched_pkg SHALL hold the state encoding (3-bit) and the default BUSY_TIMEOUT and GAP_CYCLES constants.
REQ-035 The block SHALL be a single module with no sub-modules; timeout and gap SHALL share one down-counter.

Verification
REQ-036 FIFO holds 8'hA5, enable=1, serializer busy for 10 cycles -> R_inc pulse, tx_data=8'hA5, tx_valid 1 cycle later, next pop exactly 2 gap cycles after busy falls.
REQ-037 Three bytes 8'h11, 8'h22, 8'h33 queued -> transmitted in order with exactly 3 R_inc pulses, then idle with empty=1 and R_inc=0.
REQ-038 tx_busy held 0 after tx_valid -> timeout_err=1 after 16 cycles, return to IDLE, next byte popped normally.
REQ-039 enable dropped during WAIT_DONE -> current byte completes, no further R_inc while enable=0.
REQ-040 RST asserted in WAIT_BUSY -> next cycle IDLE, tx_valid=0, timeout_err=0, tx_data=0.
REQ-041 With FIFO_TX_SCHED_CNT_EN, 5 bytes sent -> sent_cnt=5; preload 16'hFFFF and send 1 byte -> sent_cnt=0.
